// File: rtl/regfile_rename_mp.sv
// Architectural register file with rename tags for the out-of-order core.
//
// Each register holds a committed value, a busy bit and the ROB tag (qi) of
// the in-flight instruction that will produce its next value.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset (priority over all)
//   ready             state-update enable; low freezes every register
//   clear             flush: drops all rename state, commit values still land
//   rd_query/rd_pos   NRD combinational operand reads
//   rd_flag/rd_type   read valid echo; 0 = value, 1 = tag returned
//   rd_val            value, or owning tag zero-extended
//   lock/lock_rd/lock_tag            one rename per cycle from decode
//   cm_valid/cm_rd/cm_tag/cm_val     NCM in-order commits, higher index younger
//   busy_count        registered number of busy registers
module regfile_rename_mp #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned ROB_W = 4,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NCM   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           ready,
  input  logic                           clear,
  input  logic [NRD-1:0]                 rd_query,
  input  logic [NRD*$clog2(NREG)-1:0]    rd_pos,
  input  logic                           lock,
  input  logic [$clog2(NREG)-1:0]        lock_rd,
  input  logic [ROB_W-1:0]               lock_tag,
  input  logic [NCM-1:0]                 cm_valid,
  input  logic [NCM*$clog2(NREG)-1:0]    cm_rd,
  input  logic [NCM*ROB_W-1:0]           cm_tag,
  input  logic [NCM*XLEN-1:0]            cm_val,
  output logic [NRD-1:0]                 rd_flag,
  output logic [NRD-1:0]                 rd_type,
  output logic [NRD*XLEN-1:0]            rd_val,
  output logic [$clog2(NREG):0]          busy_count
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0]  val_q [NREG];
  logic [XLEN-1:0]  val_d [NREG];
  logic [ROB_W-1:0] qi_q  [NREG];
  logic [ROB_W-1:0] qi_d  [NREG];
  logic [NREG-1:0]  busy_q, busy_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  assign busy_count = cnt_q;

  // Operand reads see pre-edge state; a busy register whose owner commits this
  // cycle is forwarded from the commit bus (youngest matching port wins).
  always_comb begin : read_ports
    logic [AW-1:0]   pos;
    logic            hit;
    logic [XLEN-1:0] byp;
    rd_flag = rd_query;
    rd_type = '0;
    rd_val  = '0;
    pos     = '0;
    hit     = 1'b0;
    byp     = '0;
    for (int i = 0; i < NRD; i++) begin
      pos = rd_pos[i*AW +: AW];
      hit = 1'b0;
      byp = '0;
      for (int j = 0; j < NCM; j++) begin
        if (cm_valid[j] && (cm_tag[j*ROB_W +: ROB_W] == qi_q[pos])) begin
          hit = 1'b1;
          byp = cm_val[j*XLEN +: XLEN];
        end
      end
      if (rd_query[i] && (pos != '0)) begin
        if (!busy_q[pos]) begin
          rd_val[i*XLEN +: XLEN] = val_q[pos];
        end else if (hit) begin
          rd_val[i*XLEN +: XLEN] = byp;
        end else begin
          rd_type[i]             = 1'b1;
          rd_val[i*XLEN +: XLEN] = XLEN'(qi_q[pos]);
        end
      end
    end
  end

  always_comb begin : next_state
    logic [NREG-1:0] rel;
    logic            lock_en;
    logic [CW-1:0]   dec;
    logic [AW-1:0]   crd;
    val_d   = val_q;
    qi_d    = qi_q;
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    rel     = '0;
    dec     = '0;
    crd     = '0;
    lock_en = lock && (lock_rd != '0);
    if (ready) begin
      // Ascending port order lets the youngest commit win a shared destination.
      for (int j = 0; j < NCM; j++) begin
        crd = cm_rd[j*AW +: AW];
        if (cm_valid[j] && (crd != '0)) begin
          val_d[crd] = cm_val[j*XLEN +: XLEN];
        end
      end
      if (clear) begin
        busy_d = '0;
        for (int r = 0; r < NREG; r++) begin
          qi_d[r] = '0;
        end
        cnt_d = '0;
      end else begin
        // A stale commit (tag no longer owner) writes the value but keeps busy.
        for (int j = 0; j < NCM; j++) begin
          crd = cm_rd[j*AW +: AW];
          if (cm_valid[j] && busy_q[crd] && (qi_q[crd] == cm_tag[j*ROB_W +: ROB_W])) begin
            rel[crd] = 1'b1;
          end
        end
        for (int r = 0; r < NREG; r++) begin
          if (rel[r] && !(lock_en && (lock_rd == AW'(r)))) begin
            dec = dec + CW'(1);
          end
        end
        busy_d = busy_q & ~rel;
        // Lock overrides a same-cycle release of the same register.
        if (lock_en) begin
          qi_d[lock_rd]   = lock_tag;
          busy_d[lock_rd] = 1'b1;
        end
        cnt_d = cnt_q + CW'(lock_en && !busy_q[lock_rd]) - dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      val_q  <= '{default: '0};
      qi_q   <= '{default: '0};
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      val_q  <= val_d;
      qi_q   <= qi_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
